// File: rtl/dram_burst_xfer_if.sv
// Bus bundle between the control/arbiter side and the DRAM burst engine.
// Optional DATA_MASK_EN adds the write byte mask and DM pin.
interface dram_burst_xfer_if #(
  parameter int unsigned BURST_LEN = 8
);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam int unsigned LINE_W = 8 * BURST_LEN;

  logic              wr_en;
  logic              rd_en;
  logic              clear;
  logic [BEAT_W-1:0] offset;
  logic [LINE_W-1:0] wdata;
  logic [7:0]        dq_in;
  logic [7:0]        dq_out;
  logic              dq_oe;
  logic [LINE_W-1:0] rdata;
  logic              rdata_valid;
  logic              xfer_done;
  logic              busy;
`ifdef DATA_MASK_EN
  logic [BURST_LEN-1:0] wmask;
  logic                 dm_out;
`endif

`ifdef DATA_MASK_EN
  modport master (
    output wr_en, rd_en, clear, offset, wdata, dq_in, wmask,
    input  dq_out, dq_oe, rdata, rdata_valid, xfer_done, busy, dm_out
  );
  modport slave (
    input  wr_en, rd_en, clear, offset, wdata, dq_in, wmask,
    output dq_out, dq_oe, rdata, rdata_valid, xfer_done, busy, dm_out
  );
`else
  modport master (
    output wr_en, rd_en, clear, offset, wdata, dq_in,
    input  dq_out, dq_oe, rdata, rdata_valid, xfer_done, busy
  );
  modport slave (
    input  wr_en, rd_en, clear, offset, wdata, dq_in,
    output dq_out, dq_oe, rdata, rdata_valid, xfer_done, busy
  );
`endif
endinterface

// File: rtl/dram_burst_xfer.sv
// DRAM burst engine: serialises a line onto DQ for writes, assembles DQ beats into a line for reads.
// Optional feature macro DATA_MASK_EN adds a latched byte mask driven onto dm_out.
module dram_burst_xfer #(
  parameter int unsigned BURST_LEN = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  dram_burst_xfer_if.slave bus
);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam int unsigned LINE_W = 8 * BURST_LEN;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [BEAT_W-1:0] r_cnt;
  logic [BEAT_W-1:0] r_off;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_rdata;
  logic [7:0]        r_dq_out;
  logic              r_dq_oe;
  logic              r_rdata_valid;
  logic              r_xfer_done;
  logic              r_busy;

  state_t            w_nxt_state;
  logic [BEAT_W-1:0] w_nxt_cnt;
  logic [BEAT_W-1:0] w_nxt_off;
  logic [LINE_W-1:0] w_nxt_line;
  logic [LINE_W-1:0] w_nxt_rdata;
  logic [7:0]        w_nxt_dq_out;
  logic              w_nxt_dq_oe;
  logic              w_nxt_rdata_valid;
  logic              w_nxt_xfer_done;
  logic [BEAT_W-1:0] w_beat_idx;
  logic [BEAT_W-1:0] w_beat_nxt;

`ifdef DATA_MASK_EN
  logic [BURST_LEN-1:0] r_mask;
  logic                 r_dm_out;
  logic [BURST_LEN-1:0] w_nxt_mask;
  logic                 w_nxt_dm_out;
`endif

  // Beat position within the line wraps modulo BURST_LEN.
  assign w_beat_idx = r_off + r_cnt;
  assign w_beat_nxt = r_off + r_cnt + BEAT_W'(1);

  // Next-state and registered-output decode; outputs are precomputed for the following cycle.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_cnt         = r_cnt;
    w_nxt_off         = r_off;
    w_nxt_line        = r_line;
    w_nxt_rdata       = r_rdata;
    w_nxt_dq_out      = 8'h00;
    w_nxt_dq_oe       = 1'b0;
    w_nxt_rdata_valid = 1'b0;
    w_nxt_xfer_done   = 1'b0;
`ifdef DATA_MASK_EN
    w_nxt_mask        = r_mask;
    w_nxt_dm_out      = 1'b0;
`endif

    if (bus.clear) begin
      w_nxt_state = S_IDLE;
      w_nxt_cnt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.wr_en) begin
            w_nxt_state  = S_WRITE;
            w_nxt_cnt    = '0;
            w_nxt_off    = bus.offset;
            w_nxt_line   = bus.wdata;
            w_nxt_dq_out = bus.wdata[{bus.offset, 3'b000} +: 8];
            w_nxt_dq_oe  = 1'b1;
`ifdef DATA_MASK_EN
            w_nxt_mask   = bus.wmask;
            w_nxt_dm_out = ~bus.wmask[bus.offset];
`endif
          end else if (bus.rd_en) begin
            w_nxt_state = S_READ;
            w_nxt_cnt   = '0;
            w_nxt_off   = bus.offset;
          end
        end

        S_WRITE: begin
          if (r_cnt == LAST_BEAT) begin
            w_nxt_state     = S_DONE;
            w_nxt_cnt       = '0;
            w_nxt_xfer_done = 1'b1;
          end else begin
            w_nxt_cnt    = r_cnt + BEAT_W'(1);
            w_nxt_dq_out = r_line[{w_beat_nxt, 3'b000} +: 8];
            w_nxt_dq_oe  = 1'b1;
`ifdef DATA_MASK_EN
            w_nxt_dm_out = ~r_mask[w_beat_nxt];
`endif
          end
        end

        S_READ: begin
          w_nxt_line[{w_beat_idx, 3'b000} +: 8] = bus.dq_in;
          if (r_cnt == LAST_BEAT) begin
            w_nxt_state       = S_DONE;
            w_nxt_cnt         = '0;
            w_nxt_rdata       = w_nxt_line;
            w_nxt_rdata_valid = 1'b1;
            w_nxt_xfer_done   = 1'b1;
          end else begin
            w_nxt_cnt = r_cnt + BEAT_W'(1);
          end
        end

        S_DONE: begin
          w_nxt_state = S_IDLE;
        end

        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_off         <= '0;
      r_line        <= '0;
      r_rdata       <= '0;
      r_dq_out      <= 8'h00;
      r_dq_oe       <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_xfer_done   <= 1'b0;
      r_busy        <= 1'b0;
`ifdef DATA_MASK_EN
      r_mask        <= '0;
      r_dm_out      <= 1'b0;
`endif
    end else begin
      r_state       <= w_nxt_state;
      r_cnt         <= w_nxt_cnt;
      r_off         <= w_nxt_off;
      r_line        <= w_nxt_line;
      r_rdata       <= w_nxt_rdata;
      r_dq_out      <= w_nxt_dq_out;
      r_dq_oe       <= w_nxt_dq_oe;
      r_rdata_valid <= w_nxt_rdata_valid;
      r_xfer_done   <= w_nxt_xfer_done;
      r_busy        <= (w_nxt_state != S_IDLE);
`ifdef DATA_MASK_EN
      r_mask        <= w_nxt_mask;
      r_dm_out      <= w_nxt_dm_out;
`endif
    end
  end

  assign bus.dq_out      = r_dq_out;
  assign bus.dq_oe       = r_dq_oe;
  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.xfer_done   = r_xfer_done;
  assign bus.busy        = r_busy;
`ifdef DATA_MASK_EN
  assign bus.dm_out      = r_dm_out;
`endif

endmodule

// File: tb/tb_dram_burst_xfer.sv
// Directed self-checking bench for dram_burst_xfer (mask checks compile when DATA_MASK_EN is defined).
module tb_dram_burst_xfer;
  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_err;

  dram_burst_xfer_if #(.BURST_LEN(8)) bus ();

  dram_burst_xfer #(.BURST_LEN(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int             cnt_oe;
    int             cnt_done;
    int             cnt_valid;
    logic [7:0]     exp_b;
    n_cmp = 0;
    n_err = 0;
    nRST            = 1'b0;
    bus.wr_en       = 1'b0;
    bus.rd_en       = 1'b0;
    bus.clear       = 1'b0;
    bus.offset      = 3'd0;
    bus.wdata       = 64'h0;
    bus.dq_in       = 8'h00;
`ifdef DATA_MASK_EN
    bus.wmask       = 8'h00;
`endif

    // Reset values
    #12;
    check("rst_dq_oe",  64'(bus.dq_oe), 64'd0);
    check("rst_dq_out", 64'(bus.dq_out), 64'd0);
    check("rst_busy",   64'(bus.busy), 64'd0);
    check("rst_rdata",  bus.rdata, 64'd0);
    check("rst_valid",  64'(bus.rdata_valid), 64'd0);
    check("rst_done",   64'(bus.xfer_done), 64'd0);
    nRST = 1'b1;
    tick();

    // Write burst, offset 0; offset change after start must not matter
    bus.wr_en  = 1'b1;
    bus.offset = 3'd0;
    bus.wdata  = 64'h8877665544332211;
    tick();
    bus.wr_en  = 1'b0;
    bus.offset = 3'd5;
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'(8'h11 * (i + 1));
      check($sformatf("wr0_dq_out_%0d", i), 64'(bus.dq_out), 64'(exp_b));
      check($sformatf("wr0_dq_oe_%0d", i), 64'(bus.dq_oe), 64'd1);
      tick();
    end
    check("wr0_done",   64'(bus.xfer_done), 64'd1);
    check("wr0_oe_off", 64'(bus.dq_oe), 64'd0);
    check("wr0_dq_zero", 64'(bus.dq_out), 64'd0);
    check("wr0_novalid", 64'(bus.rdata_valid), 64'd0);
    tick();
    check("wr0_done_clr", 64'(bus.xfer_done), 64'd0);
    check("wr0_idle",     64'(bus.busy), 64'd0);

    // Read burst, offset 5, beats A0..A7
    bus.rd_en  = 1'b1;
    bus.offset = 3'd5;
    tick();
    bus.rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rd5_busy_%0d", i), 64'(bus.busy), 64'd1);
      bus.dq_in = 8'(8'hA0 + i);
      tick();
    end
    check("rd5_valid", 64'(bus.rdata_valid), 64'd1);
    check("rd5_done",  64'(bus.xfer_done), 64'd1);
    check("rd5_rdata", bus.rdata, 64'hA2A1A0A7A6A5A4A3);
    tick();
    check("rd5_valid_clr", 64'(bus.rdata_valid), 64'd0);
    check("rd5_rdata_hold", bus.rdata, 64'hA2A1A0A7A6A5A4A3);

    // Simultaneous strobes: write wins; rd_en mid-burst is not queued
    bus.wr_en  = 1'b1;
    bus.rd_en  = 1'b1;
    bus.offset = 3'd0;
    bus.wdata  = 64'h0102030405060708;
    cnt_oe = 0; cnt_done = 0; cnt_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      bus.wr_en = 1'b0;
      bus.rd_en = (k == 3);
      cnt_oe    += int'(bus.dq_oe);
      cnt_done  += int'(bus.xfer_done);
      cnt_valid += int'(bus.rdata_valid);
    end
    bus.rd_en = 1'b0;
    check("both_oe_cycles", 64'(cnt_oe), 64'd8);
    check("both_done_cnt",  64'(cnt_done), 64'd1);
    check("both_valid_cnt", 64'(cnt_valid), 64'd0);
    check("both_no_queue",  64'(bus.busy), 64'd0);
    check("both_rdata",     bus.rdata, 64'hA2A1A0A7A6A5A4A3);

    // Clear at read beat 4, then immediate new read at offset 1
    bus.rd_en  = 1'b1;
    bus.offset = 3'd0;
    tick();
    bus.rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.dq_in = 8'(8'h50 + i);
      tick();
    end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr_idle",    64'(bus.busy), 64'd0);
    check("clr_novalid", 64'(bus.rdata_valid), 64'd0);
    check("clr_nodone",  64'(bus.xfer_done), 64'd0);
    check("clr_rdata",   bus.rdata, 64'hA2A1A0A7A6A5A4A3);
    bus.rd_en  = 1'b1;
    bus.offset = 3'd1;
    tick();
    bus.rd_en = 1'b0;
    check("clr_rd_accept", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      bus.dq_in = 8'(8'h10 + i);
      tick();
    end
    check("rd1_valid", 64'(bus.rdata_valid), 64'd1);
    check("rd1_rdata", bus.rdata, 64'h1615141312111017);
    tick();

    // Clear overrides a same-cycle write strobe
    bus.clear = 1'b1;
    bus.wr_en = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    check("clrwr_idle", 64'(bus.busy), 64'd0);
    check("clrwr_oe",   64'(bus.dq_oe), 64'd0);

    // Write with wrap-around offset 6
    bus.wr_en  = 1'b1;
    bus.offset = 3'd6;
    bus.wdata  = 64'h0807060504030201;
    tick();
    bus.wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'(((6 + i) % 8) + 1);
      check($sformatf("wr6_dq_out_%0d", i), 64'(bus.dq_out), 64'(exp_b));
      tick();
    end
    check("wr6_done", 64'(bus.xfer_done), 64'd1);
    tick();

`ifdef DATA_MASK_EN
    // Mask 0x0F at offset 2 gives dm 0,0,1,1,1,1,0,0
    bus.wr_en  = 1'b1;
    bus.offset = 3'd2;
    bus.wmask  = 8'h0F;
    tick();
    bus.wr_en = 1'b0;
    bus.wmask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("dm_%0d", i), 64'(bus.dm_out), 64'((i >= 2 && i <= 5) ? 1 : 0));
      tick();
    end
    check("dm_done_zero", 64'(bus.dm_out), 64'd0);
    tick();
`endif

    // Reset during write beat 3 discards the burst
    bus.wr_en  = 1'b1;
    bus.offset = 3'd0;
    bus.wdata  = 64'h8877665544332211;
    tick();
    bus.wr_en = 1'b0;
    tick();
    tick();
    tick();
    check("rstmid_beat3", 64'(bus.dq_out), 64'h44);
    check("rstmid_oe_on", 64'(bus.dq_oe), 64'd1);
    #2 nRST = 1'b0;
    #1;
    check("rstmid_oe",    64'(bus.dq_oe), 64'd0);
    check("rstmid_dq",    64'(bus.dq_out), 64'd0);
    check("rstmid_busy",  64'(bus.busy), 64'd0);
    check("rstmid_rdata", bus.rdata, 64'd0);
    tick();
    #2 nRST = 1'b1;
    cnt_done = 0;
    cnt_oe   = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      cnt_done += int'(bus.xfer_done);
      cnt_oe   += int'(bus.busy);
    end
    check("rstmid_no_done", 64'(cnt_done), 64'd0);
    check("rstmid_no_busy", 64'(cnt_oe), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
